// File: rtl/cr16_exec_controller.sv
// CR-16 execution controller: fetch/decode/execute sequencer, PC owner and flag snapshot.
// Optional macro CR16_BRANCH_EN enables Bcond (op 0xC) and the flag snapshot register.
module cr16_exec_controller #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             fetch_req,
  output logic [WIDTH-1:0] fetch_addr,
  input  logic             fetch_ack,
  input  logic [WIDTH-1:0] instr,
  input  logic [4:0]       alu_flags,
  input  logic [WIDTH-1:0] result_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] srcAddr,
  output logic [WIDTH-1:0] dstAddr,
  output logic [WIDTH-1:0] immd,
  output logic             pcInstruction,
  output logic             rTypeInstruction,
  output logic             shiftInstruction,
  output logic             regWrite,
  output logic [2:0]       aluOp,
  output logic [3:0]       shiftAmount,
  output logic             retire,
  output logic             illegal
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] ir;
  logic [3:0]       op;
  logic             take_branch;

  logic [WIDTH-1:0] d_src, d_dst, d_immd;
  logic             d_pci, d_rt, d_sh, d_rw, d_illegal;
  logic [2:0]       d_alu;
  logic [3:0]       d_sa;

  assign op         = ir[15:12];
  assign fetch_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    fetch_req = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) nxt = S_DECODE;
      end
      S_DECODE:  nxt = d_illegal ? S_HALT : S_EXECUTE;
      S_EXECUTE: nxt = S_FETCH;
      default:   nxt = S_HALT;
    endcase
  end

  // Decode is combinational from IR; results are registered on the DECODE edge
  always_comb begin
    d_src     = '0;
    d_dst     = '0;
    d_immd    = '0;
    d_pci     = 1'b0;
    d_rt      = 1'b0;
    d_sh      = 1'b0;
    d_rw      = 1'b0;
    d_alu     = '0;
    d_sa      = '0;
    d_illegal = 1'b0;
    case (op)
      4'h0: begin
        d_illegal = ir[7];
        d_alu     = ir[6:4];
        d_rt      = 1'b1;
        d_rw      = 1'b1;
        d_src     = {{(WIDTH-4){1'b0}}, ir[3:0]};
        d_dst     = {{(WIDTH-4){1'b0}}, ir[11:8]};
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        d_alu  = op[2:0];
        d_immd = {{(WIDTH-8){ir[7]}}, ir[7:0]};
        d_rw   = 1'b1;
        d_dst  = {{(WIDTH-4){1'b0}}, ir[11:8]};
      end
      4'h8: begin
        d_sh  = 1'b1;
        d_sa  = ir[3:0];
        d_rw  = 1'b1;
        d_dst = {{(WIDTH-4){1'b0}}, ir[11:8]};
      end
`ifdef CR16_BRANCH_EN
      4'hC: begin
        d_pci  = 1'b1;
        d_immd = {{(WIDTH-8){ir[7]}}, ir[7:0]};
      end
`endif
      default: d_illegal = 1'b1;
    endcase
  end

`ifdef CR16_BRANCH_EN
  logic [4:0] flags;  // {N,Z,F,L,C} from the last executed ALU op
  logic       cond_met;

  always_comb begin
    cond_met = 1'b0;
    case (ir[11:8])
      4'd0:  cond_met =  flags[3];
      4'd1:  cond_met = ~flags[3];
      4'd2:  cond_met =  flags[0];
      4'd3:  cond_met = ~flags[0];
      4'd4:  cond_met =  flags[1];
      4'd5:  cond_met = ~flags[1];
      4'd6:  cond_met =  flags[4];
      4'd7:  cond_met = ~flags[4];
      4'd14: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  assign take_branch = (op == 4'hC) && cond_met;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 flags <= '0;
    else if (state == S_EXECUTE && !ir[15])    flags <= alu_flags;
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{alu_flags, result_in};
  assign take_branch   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir      <= '0;
      pc      <= RESET_PC;
      retire  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      retire <= 1'b0;
      if (state == S_FETCH && fetch_ack) ir <= instr;
      if (state == S_DECODE && d_illegal) illegal <= 1'b1;
      if (state == S_EXECUTE) begin
        retire <= 1'b1;
`ifdef CR16_BRANCH_EN
        pc <= take_branch ? result_in : pc + WIDTH'(1);
`else
        pc <= pc + WIDTH'(1);
`endif
      end
    end
  end

  // Controls live for the single EXECUTE cycle only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {srcAddr, dstAddr, immd} <= '0;
      {pcInstruction, rTypeInstruction, shiftInstruction, regWrite} <= '0;
      aluOp       <= '0;
      shiftAmount <= '0;
    end else if (state == S_DECODE && !d_illegal) begin
      srcAddr          <= d_src;
      dstAddr          <= d_dst;
      immd             <= d_immd;
      pcInstruction    <= d_pci;
      rTypeInstruction <= d_rt;
      shiftInstruction <= d_sh;
      regWrite         <= d_rw;
      aluOp            <= d_alu;
      shiftAmount      <= d_sa;
    end else begin
      {srcAddr, dstAddr, immd} <= '0;
      {pcInstruction, rTypeInstruction, shiftInstruction, regWrite} <= '0;
      aluOp       <= '0;
      shiftAmount <= '0;
    end
  end

endmodule
